// File: rtl/exgcd_seq.sv
// exgcd_seq: sequential extended-GCD engine using subtractive Euclid.
// One subtraction step per clock; results are registered on the finish edge
// and held until the next accepted start.
// Optional feature macro: EXGCD_INV_EN. When it is defined, the coefficient
// registers and modular subtractors are built so that the block also returns
// a^-1 mod b. When it is undefined, inv and inv_valid are tied to 0, while
// gcd, FSM behaviour and latency stay the same.
module exgcd_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] gcd,
  output logic [WIDTH-1:0] inv,
  output logic             inv_valid,
  output logic [1:0]       current_state_out
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_r0;
  logic [WIDTH-1:0] r_r1;
  logic [WIDTH-1:0] r_gcd;
  logic             r_busy;
  logic             r_done;

  logic             w_r0_zero;
  logic             w_r1_zero;
  logic             w_r0_ge;
  logic [WIDTH-1:0] w_r0_sub;
  logic [WIDTH-1:0] w_r1_sub;
  logic [WIDTH-1:0] w_fin_g;

  assign w_r0_zero = (r_r0 == '0);
  assign w_r1_zero = (r_r1 == '0);
  assign w_r0_ge   = (r_r0 >= r_r1);
  assign w_r0_sub  = r_r0 - r_r1;
  assign w_r1_sub  = r_r1 - r_r0;
  // A zero r1 is tested first, so when both registers are zero, r0 supplies gcd=0.
  assign w_fin_g   = w_r1_zero ? r_r0 : r_r1;

`ifdef EXGCD_INV_EN
  logic [WIDTH-1:0] r_t0;
  logic [WIDTH-1:0] r_t1;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_inv;
  logic             r_inv_valid;

  logic [WIDTH-1:0] w_t0_sub;
  logic [WIDTH-1:0] w_t1_sub;
  logic [WIDTH-1:0] w_fin_c;
  logic             w_fin_valid;

  // Compute (x - y) mod m for x and y in [0, m). The difference uses one extra
  // bit so that a borrow shows the result is negative; adding m then brings it
  // back into range. The final sum wraps modulo 2^WIDTH as intended.
  function automatic logic [WIDTH-1:0] modsub(input logic [WIDTH-1:0] x,
                                              input logic [WIDTH-1:0] y,
                                              input logic [WIDTH-1:0] m);
    logic [WIDTH:0] d;
    d = {1'b0, x} - {1'b0, y};
    if (d[WIDTH]) modsub = d[WIDTH-1:0] + m;
    else          modsub = d[WIDTH-1:0];
  endfunction

  assign w_t0_sub    = modsub(r_t0, r_t1, r_b);
  assign w_t1_sub    = modsub(r_t1, r_t0, r_b);
  assign w_fin_c     = w_r1_zero ? r_t0 : r_t1;
  assign w_fin_valid = (w_fin_g == WIDTH'(1)) && (r_b != '0);

  assign inv       = r_inv;
  assign inv_valid = r_inv_valid;
`else
  assign inv       = '0;
  assign inv_valid = 1'b0;
`endif

  // Control FSM plus the remainder and coefficient datapath, all in one registered block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_r0        <= '0;
      r_r1        <= '0;
      r_gcd       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
`ifdef EXGCD_INV_EN
      r_t0        <= '0;
      r_t1        <= '0;
      r_b         <= '0;
      r_inv       <= '0;
      r_inv_valid <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_r0    <= data_a;
            r_r1    <= data_b;
            r_busy  <= 1'b1;
            r_state <= ST_CALC;
`ifdef EXGCD_INV_EN
            // Every coefficient is 0 mod 1, so b==1 starts with t0 at 0 rather than 1.
            r_t0    <= (data_b == WIDTH'(1)) ? '0 : WIDTH'(1);
            r_t1    <= '0;
            r_b     <= data_b;
`endif
          end
        end

        ST_CALC: begin
          if (w_r1_zero || w_r0_zero) begin
            r_gcd       <= w_fin_g;
            r_done      <= 1'b1;
            r_state     <= ST_DONE;
`ifdef EXGCD_INV_EN
            r_inv       <= w_fin_valid ? w_fin_c : '0;
            r_inv_valid <= w_fin_valid;
`endif
          end else if (w_r0_ge) begin
            r_r0 <= w_r0_sub;
`ifdef EXGCD_INV_EN
            r_t0 <= w_t0_sub;
`endif
          end else begin
            r_r1 <= w_r1_sub;
`ifdef EXGCD_INV_EN
            r_t1 <= w_t1_sub;
`endif
          end
        end

        ST_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end

        default: begin
          // The unused encoding 2'b11 returns to IDLE with the handshake signals cleared.
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy              = r_busy;
  assign done              = r_done;
  assign gcd               = r_gcd;
  assign current_state_out = r_state;

endmodule

// File: tb/tb_exgcd_seq.sv
// tb_exgcd_seq: directed and random checks of exgcd_seq against an
// arithmetic reference model built from division-based Euclid and a
// brute-force search for the modular inverse.
module tb_exgcd_seq;

  localparam int W = 16;
`ifdef EXGCD_INV_EN
  localparam bit INV_EN = 1'b1;
`else
  localparam bit INV_EN = 1'b0;
`endif
  localparam int BUDGET = 70000;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] data_a;
  logic [W-1:0] data_b;
  logic         busy;
  logic         done;
  logic [W-1:0] gcd;
  logic [W-1:0] inv;
  logic         inv_valid;
  logic [1:0]   state;

  int n_pass;
  int n_total;

  exgcd_seq #(.WIDTH(W)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .start             (start),
    .data_a            (data_a),
    .data_b            (data_b),
    .busy              (busy),
    .done              (done),
    .gcd               (gcd),
    .inv               (inv),
    .inv_valid         (inv_valid),
    .current_state_out (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // The reference model uses division Euclid for the gcd and counts subtraction
  // steps as the sum of the quotients. It finds the inverse by direct search.
  task automatic model(input longint a, input longint b,
                       output longint g, output longint iv,
                       output bit vld, output longint steps);
    longint x;
    longint y;
    x = a; y = b; steps = 0;
    while (x != 0 && y != 0) begin
      if (x >= y) begin steps += x / y; x = x % y; end
      else        begin steps += y / x; y = y % x; end
    end
    g   = x + y;
    vld = (g == 1) && (b != 0);
    iv  = 0;
    if (vld)
      for (longint k = 0; k < b; k++)
        if (((a * k) % b) == (1 % b)) begin iv = k; break; end
    if (!INV_EN) begin iv = 0; vld = 1'b0; end
  endtask

  // Run one operation; with pulse set, also strobe start while the engine is busy.
  task automatic run(input longint a, input longint b, input bit pulse);
    longint g, iv, steps;
    bit     vld;
    int     n;
    model(a, b, g, iv, vld, steps);
    @(negedge clk);
    data_a = W'(a); data_b = W'(b); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; data_a = '0; data_b = '0;
    check("busy_after_start", 32'(busy), 32'd1);
    check("state_calc", 32'(state), 32'd1);
    n = 0;
    while (!done && n < BUDGET) begin
      @(posedge clk); #1;
      n++;
      if (pulse) begin
        start  = (n == 1 || n == 2) && !done;
        data_a = W'(16'h00AA);
        data_b = W'(16'h00BB);
      end
    end
    start = 1'b0;
    check("done_seen", 32'(done), 32'd1);
    check("latency", 32'(n), 32'(steps + 1));
    check("gcd", 32'(gcd), 32'(g));
    check("inv", 32'(inv), 32'(iv));
    check("inv_valid", 32'(inv_valid), 32'(vld));
    check("busy_with_done", 32'(busy), 32'd1);
    check("state_done", 32'(state), 32'd2);
    @(posedge clk); #1;
    check("done_pulse_end", 32'(done), 32'd0);
    check("busy_end", 32'(busy), 32'd0);
    check("state_idle", 32'(state), 32'd0);
    check("gcd_held", 32'(gcd), 32'(g));
    check("inv_held", 32'(inv), 32'(iv));
  endtask

  initial begin
    longint ra, rb;
    n_pass = 0; n_total = 0;
    rst_n = 1'b0; start = 1'b0; data_a = '0; data_b = '0;
    #1;
    check("rst_state", 32'(state), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_gcd", 32'(gcd), 32'd0);
    check("rst_inv", 32'(inv), 32'd0);
    check("rst_valid", 32'(inv_valid), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run(15, 24, 1'b0);
    run(9, 7, 1'b0);
    run(27, 81, 1'b1);
    run(0, 0, 1'b0);
    run(5, 0, 1'b0);
    run(0, 1, 1'b0);
    run(17, 3120, 1'b0);
    run(65535, 1, 1'b0);

    for (int i = 0; i < 10; i++) begin
      ra = longint'($urandom_range(0, 255));
      rb = longint'($urandom_range(0, 255));
      run(ra, rb, 1'b0);
    end

    // Assert reset in the middle of a long calculation.
    @(negedge clk);
    data_a = W'(200); data_b = W'(1); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("mid_calc_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_state", 32'(state), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_gcd", 32'(gcd), 32'd0);
    check("abort_inv", 32'(inv), 32'd0);
    check("abort_valid", 32'(inv_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run(3, 11, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/exgcd_seq.md
# exgcd_seq

Parametrised sequential extended-GCD engine. One operand pair is accepted per start/done handshake. The block returns gcd(a, b) and, when it exists, the modular inverse a⁻¹ mod b. It supersedes the fixed 8-bit exgcd datapath in the arithmetic block and feeds key-setup logic that needs the inverse plus an explicit validity flag.

## Interface
- WIDTH, 8, operand/result width in bits (≥2)
- clk  input  1  clock, all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- data_a  input  WIDTH  operand a, unsigned, sampled with start
- data_b  input  WIDTH  operand b (modulus), unsigned, sampled with start
- busy  output  1  high in CALC and DONE
- done  output  1  one-cycle pulse, results valid
- gcd  output  WIDTH  gcd(a, b); held until next accepted start
- inv  output  WIDTH  a⁻¹ mod b in [0, b); 0 when inv_valid=0
- inv_valid  output  1  high when the inverse exists; held with gcd
- current_state_out  output  2  FSM state, for debug

## Operation
- FSM: IDLE=2'b00, CALC=2'b01, DONE=2'b10; 2'b11 is illegal and recovers to IDLE next cycle.
- IDLE → CALC on a clock edge with start=1. Load r0=data_a, r1=data_b.
  - With inverse enabled, also load t0=(data_b==1)?0:1 and t1=0.
  - Invariant: r ≡ t·a (mod b).
- CALC, one step per cycle, in priority order:
  - r1==0: finish with g=r0, c=t0.
  - r0==0: finish with g=r1, c=t1.
  - r0≥r1: r0←r0−r1, t0←(t0−t1) mod b.
  - else: r1←r1−r0, t1←(t1−t0) mod b.
- Modular subtract: compute t0−t1 in WIDTH+1 bits; if negative, add b. Results always stay in [0, b).
- Finish: register gcd=g, inv_valid=(g==1)&&(b!=0), inv=inv_valid?c:0, then go to DONE.
- DONE → IDLE unconditionally after one cycle.
- Degenerate operands:
  - b==0: gcd=a, inv_valid=0.
  - a==0,b==0: gcd=0, inv_valid=0.
  - a==0,b==1: gcd=1, inv=0, inv_valid=1.
  - a≥b is legal; no pre-reduction.
- start while busy is ignored; it is not queued.
- data_a/data_b are don't-care outside the start cycle.

## Timing
- Reset (async assert, sync deassert at the system level) clears:
  - current_state_out=00, busy=0, done=0, gcd=0, inv=0, inv_valid=0
  - all r/t registers.
- Reset mid-CALC or mid-DONE aborts the operation. The result is lost; outputs return to reset values.
- Latency: let S be the number of subtraction steps, with S ≤ max(a, b).
  - done is high for the cycle starting S+1 edges after the start-sampling edge.
  - busy rises the edge after start and falls with done.
- The next start is accepted in the cycle after done, at the earliest.
- gcd/inv/inv_valid update on the edge that raises done and are stable from then on.

## Configuration
- EXGCD_INV_EN defined: t0/t1 registers and modular subtractors are built; inv/inv_valid behave as above.
- EXGCD_INV_EN undefined: coefficient datapath is removed; inv and inv_valid are tied to 0.
  - gcd values, FSM, and latency are identical in both builds.

## Test plan
- Reset then a=15, b=24, start → done 6 edges after start; gcd=3, inv_valid=0, inv=0.
- a=9, b=7 → done 7 edges after start; gcd=1, inv=4, inv_valid=1.
- a=27, b=81 → done 4 edges after start; gcd=27, inv_valid=0. Also pulse start during busy and check it is ignored.
- Edge operands: a=0,b=0 → gcd=0, valid=0; a=5,b=0 → gcd=5, valid=0; a=0,b=1 → gcd=1, inv=0, valid=1.
- WIDTH=16, a=65535, b=1 → gcd=1, inv=0, valid=1, done after 65536 edges. Also a=17, b=3120 → inv=2753.
- Assert rst_n=0 mid-CALC → state 00 and all outputs 0 immediately. After release, a=3, b=11 → inv=4. Rebuild without EXGCD_INV_EN → identical gcd, inv/inv_valid stuck at 0.
